pmem_writeback_buffer: RTL and testbench

//  Single-entry write-back (victim) buffer between the cache's pmem port and the cacheline adaptor.

---
 rtl/rv32i_types.sv | 16 +
 rtl/pmem_writeback_buffer.sv | 140 ++++++++++++++
 tb/tb_pmem_writeback_buffer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared type package for the mp3 memory path.
// Holds the write-back buffer FSM state type and the default cacheline
// geometry that the buffer uses unless it is overridden.
package rv32i_types;

   localparam int LINE_W   = 256;
   localparam int OFFSET_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACK   = 2'd1,
      RD    = 2'd2,
      DRAIN = 2'd3
   } wbbuf_state_t;

endpackage

// File: rtl/pmem_writeback_buffer.sv
// pmem_writeback_buffer
// Single-entry victim buffer between the cache pmem port and the cacheline
// adaptor. A dirty-line eviction is absorbed in one cycle. A read miss goes
// to memory ahead of the held victim. The victim drains whenever the port
// is idle. A read to the buffered line is served from the buffer, so stale
// memory data is never returned.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   mem_address     cache request address
//   mem_read        line read, held until mem_resp
//   mem_write       line eviction, held until mem_resp
//   mem_wdata       eviction data
//   mem_rdata       read data, valid while mem_resp=1
//   mem_resp        one-cycle completion pulse to the cache
//   pmem_address    line-aligned address to the adaptor
//   pmem_read       held until pmem_resp
//   pmem_write      held until pmem_resp
//   pmem_wdata      drain data (the buffer contents)
//   pmem_rdata      fill data, valid with pmem_resp
//   pmem_resp       one-cycle completion from the adaptor
module pmem_writeback_buffer #(
   parameter int ADDR_W   = 32,
   parameter int LINE_W   = rv32i_types::LINE_W,
   parameter int OFFSET_W = rv32i_types::OFFSET_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] mem_address,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [LINE_W-1:0] mem_wdata,
   output logic [LINE_W-1:0] mem_rdata,
   output logic              mem_resp,
   output logic [ADDR_W-1:0] pmem_address,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);
   import rv32i_types::*;

   localparam int TAG_W = ADDR_W - OFFSET_W;

   wbbuf_state_t      state_reg, state_next;
   logic              buf_valid_reg;
   logic [TAG_W-1:0]  buf_addr_reg;
   logic [LINE_W-1:0] buf_data_reg;
   // The read-miss line address is registered on entry to RD, so that
   // pmem_address never depends combinationally on a cache input.
   logic [TAG_W-1:0]  req_addr_reg;
   logic [LINE_W-1:0] rdata_reg;

   logic [TAG_W-1:0]  req_tag;
   logic              hit;
   logic              capture;
   logic              load_hit;
   logic              load_req;

   assign req_tag = mem_address[ADDR_W-1:OFFSET_W];
   assign hit     = buf_valid_reg && (req_tag == buf_addr_reg);

   always_comb begin
      state_next   = state_reg;
      capture      = 1'b0;
      load_hit     = 1'b0;
      load_req     = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      case (state_reg)
         IDLE: begin
            if (mem_write && (!buf_valid_reg || hit)) begin
               // Empty buffer, or the same line again: coalesce in place.
               capture    = 1'b1;
               state_next = ACK;
            end else if (mem_write) begin
               // Different line while full: make room first. The write
               // stays pending and is taken when IDLE is seen again.
               state_next = DRAIN;
            end else if (mem_read && hit) begin
               load_hit   = 1'b1;
               state_next = ACK;
            end else if (mem_read) begin
               load_req   = 1'b1;
               state_next = RD;
            end else if (buf_valid_reg) begin
               state_next = DRAIN;
            end
         end
         ACK: begin
            state_next = IDLE;
         end
         RD: begin
            pmem_read    = 1'b1;
            pmem_address = {req_addr_reg, {OFFSET_W{1'b0}}};
            if (pmem_resp) state_next = ACK;
         end
         DRAIN: begin
            // Never aborted: a request arriving now waits for the drain.
            pmem_write   = 1'b1;
            pmem_address = {buf_addr_reg, {OFFSET_W{1'b0}}};
            if (pmem_resp) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign pmem_wdata = buf_data_reg;
   assign mem_rdata  = rdata_reg;
   assign mem_resp   = (state_reg == ACK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         buf_valid_reg <= 1'b0;
         buf_addr_reg  <= '0;
         buf_data_reg  <= '0;
         req_addr_reg  <= '0;
         rdata_reg     <= '0;
      end else begin
         state_reg <= state_next;
         if (capture) begin
            buf_valid_reg <= 1'b1;
            buf_addr_reg  <= req_tag;
            buf_data_reg  <= mem_wdata;
         end
         if (load_hit) rdata_reg <= buf_data_reg;
         if (load_req) req_addr_reg <= req_tag;
         if (state_reg == RD && pmem_resp) rdata_reg <= pmem_rdata;
         if (state_reg == DRAIN && pmem_resp) buf_valid_reg <= 1'b0;
      end
   end

   // Read and write at once is a cache protocol violation.
   no_read_and_write: assert property (@(posedge clk) disable iff (rst)
      !(mem_read && mem_write));

endmodule

// File: tb/tb_pmem_writeback_buffer.sv
// Directed bench for pmem_writeback_buffer. Inputs change and outputs are
// sampled 1 time unit after the rising edge. Protocol invariants are
// checked on the falling edge.
module tb_pmem_writeback_buffer;
   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] mem_address = '0;
   logic              mem_read = 1'b0;
   logic              mem_write = 1'b0;
   logic [LINE_W-1:0] mem_wdata = '0;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_resp;
   logic [ADDR_W-1:0] pmem_address;
   logic              pmem_read;
   logic              pmem_write;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata = '0;
   logic              pmem_resp = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [LINE_W-1:0] data_a, data_b, data_c, data_d;

   pmem_writeback_buffer dut (
      .clk(clk), .rst(rst),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   // Invariant monitor
   logic prev_resp = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         checks = checks + 3;
         if ((pmem_read && pmem_write) !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL onehot: pmem_read=%b pmem_write=%b, required not both", pmem_read, pmem_write);
         end
         if (pmem_address[4:0] !== 5'd0) begin
            errors = errors + 1;
            $display("FAIL align: pmem_address=%h, required low 5 bits 0", pmem_address);
         end
         if ((mem_resp && prev_resp) !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL resp_pulse: mem_resp high 2 cycles in a row");
         end
         prev_resp = mem_resp;
      end else begin
         prev_resp = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %b, required %b", name, got, exp);
      end
   endtask

   // Present an eviction in IDLE; return in the ACK cycle with write dropped.
   task automatic load_buf(input logic [31:0] addr, input logic [LINE_W-1:0] data);
      mem_address = addr;
      mem_wdata   = data;
      mem_write   = 1'b1;
      tick();
      chk1("load_resp", mem_resp, 1'b1);
      chk1("load_no_pmem", pmem_write | pmem_read, 1'b0);
      mem_write = 1'b0;
      $display("txn write addr=%h resp=%b", addr, mem_resp);
   endtask

   // Wait (bounded) for a drain, check it, complete it.
   task automatic drain_expect(input string name, input logic [31:0] addr,
                               input logic [LINE_W-1:0] data);
      int n;
      n = 0;
      while (!pmem_write && n < 6) begin
         tick();
         n++;
      end
      checks = checks + 1;
      if (!pmem_write) begin
         errors = errors + 1;
         $display("FAIL %s_timeout: pmem_write never rose, required 1", name);
         return;
      end
      checks = checks + 2;
      if (pmem_address !== addr) begin
         errors = errors + 1;
         $display("FAIL %s_addr: got %h, required %h", name, pmem_address, addr);
      end
      if (pmem_wdata !== data) begin
         errors = errors + 1;
         $display("FAIL %s_data: got %h, required %h", name, pmem_wdata, data);
      end
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      chk1({name, "_done"}, pmem_write, 1'b0);
      chk1({name, "_valid"}, dut.buf_valid_reg, 1'b0);
      $display("txn drain addr=%h", addr);
   endtask

   task automatic test_reset();
      checks = checks + 1;
      if ({mem_resp, pmem_read, pmem_write, pmem_address, mem_rdata, pmem_wdata} !== '0) begin
         errors = errors + 1;
         $display("FAIL reset_outputs: got resp=%b rd=%b wr=%b addr=%h, required all 0",
                  mem_resp, pmem_read, pmem_write, pmem_address);
      end
      chk1("reset_valid", dut.buf_valid_reg, 1'b0);
      $display("txn reset");
   endtask

   task automatic test_evict_empty();
      load_buf(32'h0000_1040, data_a);
      tick();                         // IDLE, buffer held
      chk1("evict_idle_no_write", pmem_write, 1'b0);
      tick();                         // DRAIN
      chk1("evict_drain_now", pmem_write, 1'b1);
      drain_expect("evict", 32'h0000_1040, data_a);
   endtask

   task automatic test_read_bypass();
      load_buf(32'h0000_1040, data_a);
      mem_address = 32'h0000_2000;
      mem_read    = 1'b1;
      tick();                         // IDLE sees read miss
      tick();                         // RD
      chk1("bypass_read", pmem_read, 1'b1);
      chk1("bypass_no_write", pmem_write, 1'b0);
      checks = checks + 1;
      if (pmem_address !== 32'h0000_2000) begin
         errors = errors + 1;
         $display("FAIL bypass_addr: got %h, required %h", pmem_address, 32'h0000_2000);
      end
      tick();                         // still RD, no response yet
      chk1("bypass_wait", mem_resp, 1'b0);
      pmem_rdata = data_b;
      pmem_resp  = 1'b1;
      tick();                         // ACK
      pmem_resp  = 1'b0;
      chk1("bypass_resp", mem_resp, 1'b1);
      checks = checks + 1;
      if (mem_rdata !== data_b) begin
         errors = errors + 1;
         $display("FAIL bypass_rdata: got %h, required %h", mem_rdata, data_b);
      end
      mem_read = 1'b0;
      $display("txn read-miss addr=00002000 resp=%b", mem_resp);
      drain_expect("bypass_drain", 32'h0000_1040, data_a);
   endtask

   task automatic test_read_hit();
      load_buf(32'h0000_1040, data_a);
      mem_address = 32'h0000_105C;
      mem_read    = 1'b1;
      tick();                         // IDLE hit
      chk1("hit_not_yet", mem_resp, 1'b0);
      tick();                         // ACK
      chk1("hit_resp", mem_resp, 1'b1);
      chk1("hit_no_pmem", pmem_read | pmem_write, 1'b0);
      checks = checks + 1;
      if (mem_rdata !== data_a) begin
         errors = errors + 1;
         $display("FAIL hit_rdata: got %h, required %h", mem_rdata, data_a);
      end
      mem_read = 1'b0;
      $display("txn read-hit addr=0000105c resp=%b", mem_resp);
      drain_expect("hit_drain", 32'h0000_1040, data_a);
   endtask

   task automatic test_coalesce();
      load_buf(32'h0000_1040, data_a);
      mem_address = 32'h0000_1040;
      mem_wdata   = data_c;
      mem_write   = 1'b1;
      tick();                         // IDLE coalesce
      tick();                         // ACK
      chk1("coal_resp", mem_resp, 1'b1);
      chk1("coal_no_pmem", pmem_write, 1'b0);
      mem_write = 1'b0;
      $display("txn write-coalesce addr=00001040 resp=%b", mem_resp);
      drain_expect("coal_drain", 32'h0000_1040, data_c);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("coal_single_drain", pmem_write, 1'b0);
      end
   endtask

   task automatic test_conflict();
      load_buf(32'h0000_1040, data_a);
      mem_address = 32'h0000_3000;
      mem_wdata   = data_d;
      mem_write   = 1'b1;
      tick();                         // IDLE sees conflict
      tick();                         // DRAIN of A
      chk1("conf_draining", pmem_write, 1'b1);
      chk1("conf_no_resp", mem_resp, 1'b0);
      checks = checks + 2;
      if (pmem_address !== 32'h0000_1040) begin
         errors = errors + 1;
         $display("FAIL conf_addr: got %h, required %h", pmem_address, 32'h0000_1040);
      end
      if (pmem_wdata !== data_a) begin
         errors = errors + 1;
         $display("FAIL conf_data: got %h, required %h", pmem_wdata, data_a);
      end
      tick();
      chk1("conf_hold", mem_resp, 1'b0);
      pmem_resp = 1'b1;
      tick();                         // IDLE, pending write captured
      pmem_resp = 1'b0;
      chk1("conf_idle_no_resp", mem_resp, 1'b0);
      tick();                         // ACK
      chk1("conf_resp", mem_resp, 1'b1);
      mem_write = 1'b0;
      $display("txn write-conflict addr=00003000 resp=%b", mem_resp);
      drain_expect("conf_drain_d", 32'h0000_3000, data_d);
   endtask

   task automatic test_reset_mid_drain();
      load_buf(32'h0000_1040, data_a);
      tick();
      tick();
      chk1("rst_pre_drain", pmem_write, 1'b1);
      rst = 1'b1;
      #1;
      chk1("rst_pmem_write", pmem_write, 1'b0);
      chk1("rst_mem_resp", mem_resp, 1'b0);
      chk1("rst_valid", dut.buf_valid_reg, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      chk1("rst_after_idle", pmem_write, 1'b0);
      $display("txn reset-mid-drain");
   endtask

   initial begin
      data_a = {8{32'hAAAA_0001}};
      data_b = {8{32'hBBBB_0002}};
      data_c = {8{32'hCCCC_0003}};
      data_d = {8{32'hDDDD_0004}};
      tick();
      tick();
      rst = 1'b0;
      tick();
      test_reset();
      test_evict_empty();
      test_read_bypass();
      test_read_hit();
      test_coalesce();
      test_conflict();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
